spi_sclk_gen: RTL and testbench
===============================

# spi_sclk_gen

Transaction sequencer and serial-clock generator for the SPI master datapath. It accepts a start request with a divider and mode configuration, drives `ss_n` and `sclk`, and generates the one-cycle strobes that the downstream shift/latch stage consumes: `setup_rst`, `loadtxdata_en`, `sclk_en`, `latchout_en` and `latchin_en`. It sits directly upstream of the shift stage and is the only source of SPI-side timing in the master.

## Interface
Parameters:
- `DIV_W`, default 8: width of the half-period divider input.
- `CNT_W`, default 9: width of the SCLK cycle-count input.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-low. `rst`=0 resets the block immediately.
- `start` in 1: transaction request, sampled only in IDLE.
- `clk_div` in DIV_W: SCLK half-period length minus 1, in `clk` cycles.
- `cpol` in 1: SCLK idle level.
- `cpha` in 1: 0 = sample on leading edge, 1 = launch on leading edge.
- `sclk_cycles` in CNT_W: number of full SCLK periods N in the transaction.
- `sclk` out 1: SPI serial clock.
- `ss_n` out 1: slave select, active-low.
- `sclk_en` out 1: high while edges are scheduled (LEAD and RUN).
- `latchout_en` out 1: one-cycle launch strobe.
- `latchin_en` out 1: one-cycle sample strobe.
- `setup_rst` out 1: one-cycle pulse that clears downstream per-transaction state.
- `loadtxdata_en` out 1: one-cycle pulse that loads the downstream TX string.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle end-of-transaction pulse.

## Operation
- All outputs are registered. Reset values: `sclk`=`cpol` of the last accepted transaction (0 after reset), `ss_n`=1, `busy`=0, and all strobes and `done`=0.
- `clk_div`, `cpol`, `cpha` and `sclk_cycles` are latched when `start` is accepted. Input changes during a transaction have no effect.
- FSM states are IDLE, SETUP, LEAD, RUN and DONE.
- IDLE: `start`=1 moves to SETUP and latches the configuration. `sclk` is set to the new `cpol`.
- SETUP: lasts 1 cycle. `setup_rst`=1, `loadtxdata_en`=1, `ss_n`=0.
- LEAD: lasts `clk_div`+1 cycles. `ss_n`=0, `sclk_en`=1. When `cpha`=0, `latchout_en`=1 in the first LEAD cycle only (pre-launch of bit 0).
- RUN: consists of 2N half-periods of `clk_div`+1 cycles each.
  - In the first cycle of half-period k (k=0..2N-1), `sclk` shows its toggled value. Even k is a leading edge; odd k is a trailing edge.
  - `cpha`=0: `latchin_en`=1 on leading edges; `latchout_en`=1 on trailing edges except the final one (k=2N-1).
  - `cpha`=1: `latchout_en`=1 on leading edges; `latchin_en`=1 on trailing edges.
  - After the last half-period the FSM moves to DONE.
- DONE: lasts 1 cycle. `ss_n`=1, `done`=1, `sclk_en`=0, then the FSM moves to IDLE.
- `sclk_cycles`=0: SETUP, then LEAD, then DONE. No edges and no `latchin_en`/`latchout_en` pulses; `cpha`=0 suppresses the pre-launch pulse.
- `start` in any non-IDLE state, including DONE, is ignored. No queuing.
- The half-period counter is CNT-independent and counts 0..`clk_div`. The edge counter is CNT_W+1 bits wide, so 2N never overflows; N=2^CNT_W−1 must work.
- `latchin_en` and `latchout_en` are never high in the same cycle.

## Timing
- Start is sampled at edge T0; SETUP is visible in cycle 1.
- `ss_n` is low for exactly 1+(`clk_div`+1)(2N+1) cycles.
- `done` rises in the cycle after `ss_n` rises... more precisely, `done` is high in the same cycle in which `ss_n` returns to 1.
- Next accepted `start` is at the earliest in the IDLE cycle after DONE, giving ss_n high for at least 2 cycles between transactions.
- SCLK frequency is f_clk/(2(`clk_div`+1)); `clk_div`=0 gives f_clk/2.
- `rst` asserted mid-transaction: all outputs take their reset values asynchronously with no `done` pulse. After release the FSM is in IDLE.

## Test plan
- Mode 0 minimum case: `cpol`=0, `cpha`=0, `clk_div`=0, N=1 -> `ss_n` low cycles 1–4; `latchout_en` in cycle 2; `sclk`=1 with `latchin_en` in cycle 3; `sclk`=0 with no strobe in cycle 4; `done`=1 and `ss_n`=1 in cycle 5.
- Mode 3 with divider: `cpol`=1, `cpha`=1, `clk_div`=3, N=8 -> `sclk` idles at 1 with period 8 cycles; 8 `latchout_en` pulses on falling edges and 8 `latchin_en` pulses on rising edges; `ss_n` low for 69 cycles.
- Zero-length transaction: N=0, `clk_div`=2 -> `ss_n` low for 4 cycles, no edges, no latch strobes, one `done` pulse.
- Ignored start: `start` held high through the whole transaction -> second transaction begins in the IDLE cycle after DONE; configuration changed mid-run has no effect on the current `sclk` period.
- Reset mid-RUN: `rst`=0 at edge 5 of N=4 -> `ss_n`=1, `sclk`=0, all strobes 0 immediately; no `done` pulse; a fresh `start` after release works normally.
- Count bound: N=511, `clk_div`=0 -> exactly 1022 edges, 511 `latchin_en` pulses and 511 `latchout_en` pulses (`cpha`=0, including the pre-launch pulse).

Source files
------------

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen
// Brief    : SPI master transaction sequencer; drives ss_n/sclk and the
//            per-edge launch/sample strobes for the downstream shift stage.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [CNT_W-1:0] sclk_cycles,
    output logic             sclk,
    output logic             ss_n,
    output logic             sclk_en,
    output logic             latchout_en,
    output logic             latchin_en,
    output logic             setup_rst,
    output logic             loadtxdata_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LEAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_hcnt;
    logic [DIV_W-1:0] w_hcnt_nxt;
    logic [CNT_W:0]   r_ecnt;
    logic [CNT_W:0]   w_ecnt_nxt;
    logic [DIV_W-1:0] r_div;
    logic             r_cpol;
    logic             r_cpha;
    logic [CNT_W-1:0] r_n;

    logic             r_sclk;
    logic             r_ss_n;
    logic             r_sclk_en;
    logic             r_latchout_en;
    logic             r_latchin_en;
    logic             r_setup_rst;
    logic             r_loadtxdata_en;
    logic             r_busy;
    logic             r_done;

    logic             w_sclk_nxt;
    logic             w_ss_n_nxt;
    logic             w_sclk_en_nxt;
    logic             w_latchout_nxt;
    logic             w_latchin_nxt;
    logic             w_setup_rst_nxt;
    logic             w_loadtx_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic             w_hp_end;
    logic             w_edge;
    logic [CNT_W:0]   w_k;
    logic [CNT_W:0]   w_two_n;
    logic [CNT_W:0]   w_last_k;

    assign w_hp_end = (r_hcnt == r_div);
    // Extra edge-counter bit keeps 2N representable for the largest N.
    assign w_two_n  = {r_n, 1'b0};
    assign w_last_k = w_two_n - (CNT_W+1)'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_hcnt_nxt      = r_hcnt;
        w_ecnt_nxt      = r_ecnt;
        w_sclk_nxt      = r_sclk;
        w_ss_n_nxt      = 1'b0;
        w_sclk_en_nxt   = 1'b0;
        w_latchout_nxt  = 1'b0;
        w_latchin_nxt   = 1'b0;
        w_setup_rst_nxt = 1'b0;
        w_loadtx_nxt    = 1'b0;
        w_busy_nxt      = 1'b1;
        w_done_nxt      = 1'b0;
        w_edge          = 1'b0;
        w_k             = '0;

        case (r_state)
            S_IDLE: begin
                w_ss_n_nxt = 1'b1;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt     = S_SETUP;
                    w_sclk_nxt      = cpol;
                    w_ss_n_nxt      = 1'b0;
                    w_setup_rst_nxt = 1'b1;
                    w_loadtx_nxt    = 1'b1;
                    w_busy_nxt      = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nxt    = S_LEAD;
                w_hcnt_nxt     = '0;
                w_sclk_en_nxt  = 1'b1;
                w_latchout_nxt = ~r_cpha && (r_n != '0);
            end
            S_LEAD: begin
                w_sclk_en_nxt = 1'b1;
                w_hcnt_nxt    = r_hcnt + DIV_W'(1);
                if (w_hp_end) begin
                    w_hcnt_nxt = '0;
                    if (r_n == '0) begin
                        w_state_nxt   = S_DONE;
                        w_ss_n_nxt    = 1'b1;
                        w_sclk_en_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_ecnt_nxt  = '0;
                        w_edge      = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_sclk_en_nxt = 1'b1;
                w_hcnt_nxt    = r_hcnt + DIV_W'(1);
                if (w_hp_end) begin
                    w_hcnt_nxt = '0;
                    if (r_ecnt == w_last_k) begin
                        w_state_nxt   = S_DONE;
                        w_ss_n_nxt    = 1'b1;
                        w_sclk_en_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_ecnt_nxt = r_ecnt + (CNT_W+1)'(1);
                        w_k        = r_ecnt + (CNT_W+1)'(1);
                        w_edge     = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ss_n_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ss_n_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Even half-periods are leading edges; the last trailing edge of
        // mode cpha=0 has no bit left to launch.
        if (w_edge) begin
            w_sclk_nxt = ~r_sclk;
            if (!w_k[0]) begin
                w_latchout_nxt = r_cpha;
                w_latchin_nxt  = ~r_cpha;
            end else begin
                w_latchin_nxt  = r_cpha;
                w_latchout_nxt = ~r_cpha && (w_k != w_last_k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_hcnt          <= '0;
            r_ecnt          <= '0;
            r_div           <= '0;
            r_cpol          <= 1'b0;
            r_cpha          <= 1'b0;
            r_n             <= '0;
            r_sclk          <= 1'b0;
            r_ss_n          <= 1'b1;
            r_sclk_en       <= 1'b0;
            r_latchout_en   <= 1'b0;
            r_latchin_en    <= 1'b0;
            r_setup_rst     <= 1'b0;
            r_loadtxdata_en <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_hcnt          <= w_hcnt_nxt;
            r_ecnt          <= w_ecnt_nxt;
            r_sclk          <= w_sclk_nxt;
            r_ss_n          <= w_ss_n_nxt;
            r_sclk_en       <= w_sclk_en_nxt;
            r_latchout_en   <= w_latchout_nxt;
            r_latchin_en    <= w_latchin_nxt;
            r_setup_rst     <= w_setup_rst_nxt;
            r_loadtxdata_en <= w_loadtx_nxt;
            r_busy          <= w_busy_nxt;
            r_done          <= w_done_nxt;
            if (r_state == S_IDLE && start) begin
                r_div  <= clk_div;
                r_cpol <= cpol;
                r_cpha <= cpha;
                r_n    <= sclk_cycles;
            end
        end
    end

    assign sclk          = r_sclk;
    assign ss_n          = r_ss_n;
    assign sclk_en       = r_sclk_en;
    assign latchout_en   = r_latchout_en;
    assign latchin_en    = r_latchin_en;
    assign setup_rst     = r_setup_rst;
    assign loadtxdata_en = r_loadtxdata_en;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sclk_gen
// Brief    : Scoreboard bench for spi_sclk_gen; stimulus queues a per-
//            transaction signature, a monitor measures it and compares at done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sclk_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] clk_div = '0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [8:0] sclk_cycles = '0;
    logic       sclk, ss_n, sclk_en, latchout_en, latchin_en;
    logic       setup_rst, loadtxdata_en, busy, done;

    spi_sclk_gen #(.DIV_W(8), .CNT_W(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .clk_div       (clk_div),
        .cpol          (cpol),
        .cpha          (cpha),
        .sclk_cycles   (sclk_cycles),
        .sclk          (sclk),
        .ss_n          (ss_n),
        .sclk_en       (sclk_en),
        .latchout_en   (latchout_en),
        .latchin_en    (latchin_en),
        .setup_rst     (setup_rst),
        .loadtxdata_en (loadtxdata_en),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ss_low;
        int toggles;
        int lin;
        int lout;
        int first_lout;
        int first_lin;
        int lin_sclk;
        int setup;
        int load;
        int en;
        int ivl_min;
        int ivl_max;
        int stray;
        int end_sclk;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pushed = 0;
    int   n_done = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    function automatic rec_t mk(input int ss_low, input int toggles, input int lin,
                                input int lout, input int first_lout, input int first_lin,
                                input int lin_sclk, input int en, input int ivl,
                                input int stray, input int end_sclk);
        rec_t r;
        r.ss_low = ss_low;   r.toggles = toggles;       r.lin = lin;
        r.lout = lout;       r.first_lout = first_lout; r.first_lin = first_lin;
        r.lin_sclk = lin_sclk;
        r.setup = 1;         r.load = 1;                r.en = en;
        r.ivl_min = ivl;     r.ivl_max = ivl;           r.stray = stray;
        r.end_sclk = end_sclk;
        return r;
    endfunction

    // ---------------- monitor ----------------
    rec_t m;
    bit   in_tx = 0;
    int   cyc = 0;
    int   last_tog = 0;
    int   overlap = 0;
    logic prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            in_tx = 0;
        end else begin
            if (!ss_n || done) begin
                if (!in_tx) begin
                    in_tx = 1;
                    cyc = 0;
                    last_tog = 0;
                    overlap = 0;
                    m = mk(0, 0, 0, 0, -1, -1, -1, 0, 0, 0, 0);
                    m.setup = 0;
                    m.load = 0;
                end
                cyc++;
                if (!ss_n) m.ss_low++;
                if (setup_rst) m.setup++;
                if (loadtxdata_en) m.load++;
                if (sclk_en) m.en++;
                if (latchin_en && latchout_en) overlap++;
                if (cyc >= 2 && !done) begin
                    if (sclk != prev_sclk) begin
                        m.toggles++;
                        if (last_tog > 0) begin
                            if (m.ivl_max == 0 || (cyc - last_tog) < m.ivl_min) m.ivl_min = cyc - last_tog;
                            if ((cyc - last_tog) > m.ivl_max) m.ivl_max = cyc - last_tog;
                        end
                        last_tog = cyc;
                    end else if (latchin_en || latchout_en) begin
                        m.stray++;
                    end
                end
                if (latchin_en) begin
                    m.lin++;
                    if (m.first_lin < 0) begin
                        m.first_lin = cyc;
                        m.lin_sclk = int'(sclk);
                    end
                end
                if (latchout_en) begin
                    m.lout++;
                    if (m.first_lout < 0) m.first_lout = cyc;
                end
                if (done) begin
                    rec_t e;
                    n_done++;
                    in_tx = 0;
                    m.end_sclk = int'(sclk);
                    chk("ss_n_high_at_done", int'(ss_n), 1);
                    chk("strobe_overlap", overlap, 0);
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("ss_low_cycles", m.ss_low, e.ss_low);
                        chk("sclk_toggles", m.toggles, e.toggles);
                        chk("latchin_count", m.lin, e.lin);
                        chk("latchout_count", m.lout, e.lout);
                        chk("first_latchout_cyc", m.first_lout, e.first_lout);
                        chk("first_latchin_cyc", m.first_lin, e.first_lin);
                        chk("sclk_at_first_latchin", m.lin_sclk, e.lin_sclk);
                        chk("setup_rst_count", m.setup, e.setup);
                        chk("loadtx_count", m.load, e.load);
                        chk("sclk_en_cycles", m.en, e.en);
                        chk("half_period_min", m.ivl_min, e.ivl_min);
                        chk("half_period_max", m.ivl_max, e.ivl_max);
                        chk("non_edge_strobes", m.stray, e.stray);
                        chk("sclk_at_done", m.end_sclk, e.end_sclk);
                    end
                end
            end
            prev_sclk = sclk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic issue(input int d, input logic pol, input logic pha, input int n, input rec_t e);
        @(negedge clk);
        clk_div     = 8'(d);
        cpol        = pol;
        cpha        = pha;
        sclk_cycles = 9'(n);
        start       = 1'b1;
        q.push_back(e);
        n_pushed++;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_ss_n", int'(ss_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en, done}), 0);
        rst = 1'b1;
        @(negedge clk);

        // ss_low, toggles, lin, lout, first_lout, first_lin, lin_sclk, en, ivl, stray, end_sclk
        issue(0, 1'b0, 1'b0, 1, mk(4, 2, 1, 1, 2, 3, 1, 3, 1, 1, 0));
        issue(3, 1'b1, 1'b1, 8, mk(69, 16, 8, 8, 6, 10, 1, 68, 4, 0, 1));
        issue(2, 1'b1, 1'b0, 0, mk(4, 0, 0, 0, -1, -1, -1, 3, 0, 0, 1));
        issue(1, 1'b0, 1'b1, 3, mk(15, 6, 3, 3, 4, 6, 0, 14, 2, 0, 0));
        issue(0, 1'b1, 1'b0, 2, mk(6, 4, 2, 2, 2, 3, 0, 5, 1, 1, 1));

        // start held high: configuration edits mid-run must not disturb it
        @(negedge clk);
        clk_div = 8'd1; cpol = 1'b0; cpha = 1'b0; sclk_cycles = 9'd2;
        start = 1'b1;
        q.push_back(mk(11, 4, 2, 2, 2, 4, 1, 10, 2, 1, 0));
        n_pushed++;
        @(negedge clk);
        q.push_back(mk(10, 2, 1, 1, 5, 8, 1, 9, 3, 0, 1));
        n_pushed++;
        repeat (2) @(negedge clk);
        clk_div = 8'd2; cpol = 1'b1; cpha = 1'b1; sclk_cycles = 9'd1;
        wait_done(200);
        @(negedge clk);
        chk("gap_idle_busy", int'(busy), 0);
        chk("gap_idle_ss_n", int'(ss_n), 1);
        @(negedge clk);
        chk("restart_setup_rst", int'(setup_rst), 1);
        start = 1'b0;
        wait_done(200);
        @(negedge clk);

        // reset in the middle of RUN
        @(negedge clk);
        clk_div = 8'd0; cpol = 1'b0; cpha = 1'b0; sclk_cycles = 9'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_sclk", int'(sclk), 1);
        chk("pre_rst_latchin", int'(latchin_en), 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_ss_n", int'(ss_n), 1);
        chk("async_rst_sclk", int'(sclk), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_strobes", int'({sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en, done}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_done", int'(done), 0);
        issue(0, 1'b0, 1'b0, 1, mk(4, 2, 1, 1, 2, 3, 1, 3, 1, 1, 0));

        // largest transaction
        issue(0, 1'b0, 1'b0, 511, mk(1024, 1022, 511, 511, 2, 3, 1, 1023, 1, 1, 0));

        repeat (3) @(negedge clk);
        chk("done_pulses", n_done, n_pushed);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
